fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-register PC and direct instruction-RAM path of the CPU top. Holds the fetch PC, issues one read per cycle to a synchronous instruction RAM, buffers returned words with their addresses in a DEPTH-entry prefetch queue, and hands them to the decoder over a valid/ready handshake. A redirect from execute (branch or PC write) flushes all speculative state.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
// Optional feature macro used by fetch_unit: FETCH_PERF_CNT_EN.
package fetch_unit_pkg;

    localparam int unsigned FULLW = 32;
    localparam int unsigned FETCH_DEPTH = 4;
    localparam logic [FULLW-1:0] FETCH_RESET_PC = '0;
    localparam int unsigned FETCH_INCR = 4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue holding {pc, instr} pairs; flush wins over push.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = FULLW,
    parameter int unsigned DEPTH = FETCH_DEPTH,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_pc_i,
    input  logic [WIDTH-1:0] push_instr_i,
    input  logic             pop_i,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_pc_o,
    output logic [WIDTH-1:0] head_instr_o
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_pop;
    logic               do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {push_pc_i, push_instr_i};
    end

    // Gate head with occupancy so an empty queue presents zeros.
    always_comb begin
        head_pc_o    = '0;
        head_instr_o = '0;
        if (count_q != '0) begin
            {head_pc_o, head_instr_o} = mem_q[rd_ptr_q];
        end
    end

    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!nreset)
        !(do_push && !do_pop && (count_q == CW'(DEPTH))))
        else $error("fetch_fifo push into full queue");

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, one-deep RAM inflight tracking, prefetch queue.
// Optional FETCH_PERF_CNT_EN adds saturating push/redirect counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      WIDTH    = FULLW,
    parameter int unsigned      DEPTH    = FETCH_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC),
    parameter int unsigned      INCR     = FETCH_INCR
) (
    input  logic             clk,
    input  logic             nreset,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic [CW-1:0]    count;
    logic [CW:0]      credit_used;
    logic             push;
    logic             pop;

    // Credit counts the word still in the RAM pipe; a same-cycle pop is not credited.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign imem_req    = nreset && !redirect_valid && (credit_used < DepthW);
    assign imem_addr   = fetch_pc_q;
    assign push        = inflight_q && !redirect_valid;
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_addr;
            inflight_d = 1'b0;
        end else if (imem_req) begin
            fetch_pc_d    = fetch_pc_q + WIDTH'(INCR);
            inflight_pc_d = fetch_pc_q;
            inflight_d    = 1'b1;
        end else begin
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .nreset       (nreset),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_pc_i    (inflight_pc_q),
        .push_instr_i (imem_data),
        .pop_i        (pop),
        .count_o      (count),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push)           fetch_cnt_q <= sat_inc32(fetch_cnt_q);
            if (redirect_valid) flush_cnt_q <= sat_inc32(flush_cnt_q);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default config plus an 8-bit wrap instance).
module tb_fetch_unit;

    logic        clk;
    logic        nreset;
    logic [31:0] imem_addr, imem_data, redirect_addr, out_instr, out_pc;
    logic        imem_req, redirect_valid, out_valid, out_ready;
    logic [7:0]  imem_addr8, imem_data8, out_instr8, out_pc8;
    logic        imem_req8, out_valid8;
    logic        redirect_valid8 = 1'b0;
    logic [7:0]  redirect_addr8 = 8'h00;
    logic        out_ready8 = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_fetch_cnt8, perf_flush_cnt8;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit u_dut (
        .clk            (clk),
        .nreset         (nreset),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    fetch_unit #(
        .WIDTH    (8),
        .RESET_PC (8'hF8)
    ) u_dut8 (
        .clk            (clk),
        .nreset         (nreset),
        .imem_addr      (imem_addr8),
        .imem_req       (imem_req8),
        .imem_data      (imem_data8),
        .redirect_valid (redirect_valid8),
        .redirect_addr  (redirect_addr8),
        .out_valid      (out_valid8),
        .out_ready      (out_ready8),
        .out_instr      (out_instr8),
        .out_pc         (out_pc8)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt8),
        .perf_flush_cnt (perf_flush_cnt8)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction RAMs: word at address n is n+0x100 (n^0xA5 for the 8-bit one).
    always @(posedge clk) begin
        if (imem_req)  imem_data  <= imem_addr + 32'h100;
        if (imem_req8) imem_data8 <= imem_addr8 ^ 8'hA5;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench #1 after the sampling point of cycle 0.
    task automatic do_reset();
        #2 nreset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_held_req", 32'(imem_req), 32'd0);
        nreset = 1'b1;
        #1;
        check("c0_imem_req", 32'(imem_req), 32'd1);
        check("c0_imem_addr", imem_addr, 32'h0);
        check("c0_imem_addr8", 32'(imem_addr8), 32'hF8);
    endtask

    initial begin
        int reqs;
        logic [7:0] exp8 [4];
        exp8[0] = 8'hF8; exp8[1] = 8'hFC; exp8[2] = 8'h00; exp8[3] = 8'h04;
        nreset         = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;

        // Streaming from reset, one instruction per cycle; 8-bit PC wraps.
        do_reset();
        next_cycle();
        check("c1_out_valid", 32'(out_valid), 32'd0);
        for (int c = 2; c < 8; c++) begin
            next_cycle();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", out_pc, 32'(4 * (c - 2)));
            check("stream_instr", out_instr, 32'(4 * (c - 2)) + 32'h100);
            if (c < 6) check("wrap_pc8", 32'(out_pc8), 32'(exp8[c-2]));
        end

        // Backpressure: four words held, issue stalls, release in order.
        out_ready = 1'b0;
        do_reset();
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            if (imem_req) reqs++;
            next_cycle();
        end
        check("bp_req_count", 32'(reqs), 32'd4);
        check("bp_req_low", 32'(imem_req), 32'd0);
        check("bp_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        #1;
        check("bp_no_credit_for_pop", 32'(imem_req), 32'd0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            check("bp_rel_valid", 32'(out_valid), 32'd1);
            check("bp_rel_pc", out_pc, 32'(4 * k));
            if (k == 1) check("bp_resume_req", 32'(imem_req), 32'd1);
        end

        // Redirect at cycle 5 with a request inflight, then handshake+back-to-back redirects.
        do_reset();
        for (int c = 1; c < 6; c++) next_cycle();
        check("rd_c5_pc", out_pc, 32'd12);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        #1;
        check("rd_c5_no_req", 32'(imem_req), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check("rd_c6_req", 32'(imem_req), 32'd1);
        check("rd_c6_addr", imem_addr, 32'h40);
        check("rd_c6_valid", 32'(out_valid), 32'd0);
        next_cycle();
        check("rd_c7_valid", 32'(out_valid), 32'd0);
        next_cycle();
        check("rd_c8_valid", 32'(out_valid), 32'd1);
        check("rd_c8_pc", out_pc, 32'h40);
        check("rd_c8_instr", out_instr, 32'h140);
        next_cycle();
        check("rd_c9_pc", out_pc, 32'h44);
        next_cycle();
        check("rd_c10_pc", out_pc, 32'h48);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h80;
        next_cycle();
        redirect_addr = 32'hC0;
        check("b2b_c11_valid", 32'(out_valid), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check("b2b_c12_addr", imem_addr, 32'hC0);
        check("b2b_c12_valid", 32'(out_valid), 32'd0);
        next_cycle();
        check("b2b_c13_valid", 32'(out_valid), 32'd0);
        next_cycle();
        check("b2b_c14_valid", 32'(out_valid), 32'd1);
        check("b2b_c14_pc", out_pc, 32'hC0);
        check("b2b_c14_instr", out_instr, 32'h1C0);
        next_cycle();
        check("pre_rst_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset mid-stream, restart, three redirects.
        do_reset();
        next_cycle();
        next_cycle();
        check("rst2_c2_pc", out_pc, 32'h0);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        next_cycle();
        next_cycle();
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check("rst2_c6_addr", imem_addr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
        check("perf_flush_3", perf_flush_cnt, 32'd3);
        check("perf_fetch_2", perf_fetch_cnt, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
